// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port data memory between the core load/store path and
// the loader port; one access per cycle, read data returned one cycle after grant.
module dmem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_LOCK   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  c_req,
  input  logic                  c_we,
  input  logic [ADDR_WIDTH-1:0] c_addr,
  input  logic [DATA_WIDTH-1:0] c_wdata,
  output logic                  c_gnt,
  output logic                  c_rvalid,
  output logic [DATA_WIDTH-1:0] c_rdata,
  input  logic                  l_req,
  input  logic                  l_we,
  input  logic                  l_lock,
  input  logic [ADDR_WIDTH-1:0] l_addr,
  input  logic [DATA_WIDTH-1:0] l_wdata,
  output logic                  l_gnt,
  output logic                  l_rvalid,
  output logic [DATA_WIDTH-1:0] l_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  core_stall
);

  localparam int CW = $clog2(MAX_LOCK + 1);

  typedef enum logic {
    PRIO_CORE,
    PRIO_LOADER
  } prio_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CORE,
    OWN_LOADER
  } owner_t;

  prio_t          r_prio;
  prio_t          w_prio_next;
  logic [CW-1:0]  r_lock_cnt;
  logic [CW-1:0]  w_lock_cnt_next;
  logic           r_l_gnt_last;
  owner_t         r_rd_owner;
  owner_t         w_rd_owner_next;

  logic           w_c_gnt;
  logic           w_l_gnt;
  logic           w_lock_force;
  logic           w_yield;
  logic           w_lock_full;

  assign w_lock_full = (r_lock_cnt == CW'(MAX_LOCK));

  // Grant decision; everything is held at zero while rst is asserted.
  always_comb begin
    w_c_gnt      = 1'b0;
    w_l_gnt      = 1'b0;
    w_yield      = 1'b0;
    w_lock_force = l_lock & l_req & r_l_gnt_last;
    if (!rst) begin
      if (w_lock_force) begin
        if (c_req && w_lock_full) begin
          w_c_gnt = 1'b1;
          w_yield = 1'b1;
        end else begin
          w_l_gnt = 1'b1;
        end
      end else if (c_req && l_req) begin
        if (r_prio == PRIO_CORE) w_c_gnt = 1'b1;
        else                     w_l_gnt = 1'b1;
      end else begin
        w_c_gnt = c_req;
        w_l_gnt = l_req;
      end
    end
  end

  // A forced yield also hands priority back to the loader so it resumes next.
  always_comb begin
    w_prio_next = r_prio;
    if ((c_req && l_req && !w_lock_force) || w_yield) begin
      w_prio_next = w_c_gnt ? PRIO_LOADER : PRIO_CORE;
    end

    w_lock_cnt_next = r_lock_cnt;
    if (w_c_gnt || !l_lock || !l_req) begin
      w_lock_cnt_next = '0;
    end else if (w_l_gnt && !w_lock_full) begin
      w_lock_cnt_next = r_lock_cnt + 1'b1;
    end

    w_rd_owner_next = OWN_NONE;
    if (w_c_gnt && !c_we) begin
      w_rd_owner_next = OWN_CORE;
    end else if (w_l_gnt && !l_we) begin
      w_rd_owner_next = OWN_LOADER;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio       <= PRIO_CORE;
      r_lock_cnt   <= '0;
      r_l_gnt_last <= 1'b0;
      r_rd_owner   <= OWN_NONE;
    end else begin
      r_prio       <= w_prio_next;
      r_lock_cnt   <= w_lock_cnt_next;
      r_l_gnt_last <= w_l_gnt;
      r_rd_owner   <= w_rd_owner_next;
    end
  end

  assign c_gnt      = w_c_gnt;
  assign l_gnt      = w_l_gnt;
  assign core_stall = ~rst & c_req & ~w_c_gnt;

  assign mem_en    = w_c_gnt | w_l_gnt;
  assign mem_we    = w_c_gnt ? c_we    : (w_l_gnt ? l_we    : 1'b0);
  assign mem_addr  = w_c_gnt ? c_addr  : (w_l_gnt ? l_addr  : '0);
  assign mem_wdata = w_c_gnt ? c_wdata : (w_l_gnt ? l_wdata : '0);

  // Pending return is dropped if reset lands on the return cycle.
  assign c_rvalid = ~rst & (r_rd_owner == OWN_CORE);
  assign l_rvalid = ~rst & (r_rd_owner == OWN_LOADER);
  assign c_rdata  = c_rvalid ? mem_rdata : '0;
  assign l_rdata  = l_rvalid ? mem_rdata : '0;

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port data memory of the single-cycle RISC-V core between two requesters: the core's load/store path, and the loader port that the bench and boot logic use to preload or inspect memory.
- Grants at most one access per cycle and returns read data one cycle after the grant.
- Drives a stall to the core while the core's request is not granted.
- Sits between the core top and the data memory instance.

Parameters:
- ADDR_WIDTH, 32, byte address width of all address ports.
- DATA_WIDTH, 32, data width of all data ports.
- MAX_LOCK, 8, maximum consecutive locked loader grants before a forced yield to a pending core request.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- c_req  in  1  core access request.
- c_we  in  1  core write enable (0 = read).
- c_addr  in  ADDR_WIDTH  core address.
- c_wdata  in  DATA_WIDTH  core write data.
- c_gnt  out  1  core granted this cycle.
- c_rvalid  out  1  core read data valid.
- c_rdata  out  DATA_WIDTH  core read data.
- l_req  in  1  loader access request.
- l_we  in  1  loader write enable.
- l_lock  in  1  loader requests to hold the port across consecutive cycles.
- l_addr  in  ADDR_WIDTH  loader address.
- l_wdata  in  DATA_WIDTH  loader write data.
- l_gnt  out  1  loader granted this cycle.
- l_rvalid  out  1  loader read data valid.
- l_rdata  out  DATA_WIDTH  loader read data.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data; valid the cycle after mem_en with mem_we=0.
- core_stall  out  1  c_req & ~c_gnt.

Behaviour:
- Reset values, while rst=1:
  - Outputs: c_gnt=0, l_gnt=0, mem_en=0, mem_we=0, c_rvalid=0, l_rvalid=0, core_stall=0; mem_addr, mem_wdata, c_rdata, l_rdata driven 0.
  - State: prio=CORE, lock_cnt=0, rd_owner=NONE.
- Grant (combinational from registered state, same cycle as request):
  - Only one requester active: that requester is granted.
  - Both active, lock not in force: the requester indicated by prio wins.
  - Lock in force (l_lock=1, l_req=1 and the loader was granted last cycle): loader wins, unless lock_cnt==MAX_LOCK and c_req=1. In that case the core wins (forced yield).
- Priority update:
  - After any cycle with both requesting and no lock in force, prio flips to the loser (round-robin).
  - Single-requester grants leave prio unchanged.
- lock_cnt:
  - Increments on each loader grant with l_lock=1, saturating at MAX_LOCK.
  - Clears on any core grant, or on any cycle where l_lock=0 or l_req=0.
- Memory mux:
  - mem_en = c_gnt | l_gnt.
  - mem_we, mem_addr, mem_wdata taken from the granted requester; all 0 when neither is granted.
- Read return:
  - A granted read (we=0) registers rd_owner.
  - Next cycle, the owner's rvalid=1 and its rdata=mem_rdata. The other rdata is 0.
  - Writes never produce rvalid.
  - Latency is fixed at 1 cycle.
  - Back-to-back reads from alternating owners return in grant order, one per cycle.
- Core stall: the core holds c_req, c_we, c_addr and c_wdata stable while core_stall=1.
- Reset mid-operation: rst asserted the cycle after a read grant forces rvalid=0 that cycle, and the pending return is discarded. State returns to reset values.
- Write/read same address in consecutive cycles: the read returns the newly written value; no bypass is needed, the memory is synchronous.

Test Plan:
- Core read only: c_req=1, c_we=0, c_addr=0x10, memory holds 0xDEADBEEF.
  - Same cycle: c_gnt=1, mem_addr=0x10.
  - Next cycle: c_rvalid=1, c_rdata=0xDEADBEEF, l_rvalid=0, core_stall=0.
- Simultaneous reads, no lock, both held 4 cycles from reset:
  - Grants go C, L, C, L.
  - core_stall=1 in cycles 2 and 4.
  - rvalids alternate one cycle later with the matching data.
- Loader write: l_req=1, l_we=1, l_addr=0x20, l_wdata=0x12345678, then a core read of 0x20.
  - Write cycle: mem_we=1; no rvalid follows.
  - Core read returns 0x12345678.
- Lock cap with MAX_LOCK=4: l_lock=1 and l_req=1 held, c_req=1 from cycle 0.
  - prio=CORE from reset, so the first grant goes to the core.
  - Loader then gets 4 consecutive grants, the core 1 forced grant, then the loader resumes.
  - lock_cnt clears on the core grant.
- Reset mid-read: loader read granted, rst=1 next cycle.
  - l_rvalid=0 and all grants 0 that cycle.
  - After rst=0, the core alone is granted immediately.
- Idle: no requests for 10 cycles → mem_en=0, both rvalids 0, prio unchanged.
